out_port_uart_tx: RTL
=====================

// Module: out_port_uart_tx
// PURPOSE
//  Serial transmitter fed by a CPU output port. Each one-cycle write strobe pushes the
//  8-bit port value into a small FIFO. The FIFO drains into an 8N1 UART frame on tx.
//  Sits downstream of output_module: wr_data is an out_from_pX bus, and wr_en is that
//  port's decoded write pulse (we && sel_port==X). Lets programs emit bytes without polling.
// PARAMETERS
//  CLK_DIV     16  clk cycles per serial bit; legal range 2..65535
//  FIFO_DEPTH  4   FIFO entries; power of two, >=2
//  AW          2   pointer width = log2(FIFO_DEPTH)
// PORTS
//  clk         in   1       system clock; all logic on rising edge
//  reset       in   1       synchronous, active-high reset
//  wr_en       in   1       one-cycle push strobe (CPU wrote the port)
//  wr_data     in   8       byte to queue
//  tx          out  1       serial line; idles high
//  busy        out  1       1 while a frame is on the line or FIFO non-empty
//  full        out  1       FIFO holds FIFO_DEPTH entries
//  fifo_count  out  AW+1    entries currently queued, 0..FIFO_DEPTH
//  overflow    out  1       sticky: a push was dropped because FIFO was full
// BEHAVIOUR
//  Reset, sampled at a clock edge, sets:
//   - tx=1, busy=0, full=0, fifo_count=0, overflow=0
//   - FSM=IDLE, FIFO pointers=0, bit counter=0, divider=0
//  Reset aborts any frame in progress at once. tx returns high the next cycle; queued
//  bytes are discarded.
//  FIFO:
//   - Push at edge when wr_en=1 and full=0 (full as sampled before that edge).
//   - Push with full=1 is dropped and sets overflow=1. Only reset clears overflow.
//   - Pop only by the FSM in IDLE when fifo_count>0.
//   - Push and pop in the same edge: fifo_count unchanged, both take effect.
//   - Pointers wrap modulo FIFO_DEPTH; full = (fifo_count==FIFO_DEPTH).
//  FSM (all outputs registered):
//   - IDLE: tx=1. If fifo_count>0: load head byte into shift reg, pop, divider=0 -> START.
//   - START: tx=0 for CLK_DIV cycles -> DATA.
//   - DATA: 8 bits LSB first, each CLK_DIV cycles; after bit 7 -> PARITY if enabled, else STOP.
//   - PARITY (PARITY_EN only): tx=^byte (even parity) for CLK_DIV cycles -> STOP.
//   - STOP: tx=1 for CLK_DIV cycles -> IDLE.
//  Latency: wr_en at edge E0 into an empty FIFO with FSM idle. Pop at E1; tx falls after E1.
//  Frame length: 10*CLK_DIV cycles (11*CLK_DIV with parity).
//  Back-to-back: IDLE lasts exactly 1 cycle between frames if the FIFO is non-empty.
//  busy = (FSM!=IDLE) | (fifo_count!=0). Registered-equivalent: no glitches on tx.
//  Divider counts 0..CLK_DIV-1; bit advances on terminal count. No fractional baud.
// CONFIGURATION
//  `define OUT_PORT_UART_PARITY_EN
//   - Defined: PARITY state compiled in; frame is start+8 data+even parity+stop.
//   - Undefined: no PARITY state or logic; frame is 8N1.
//  The macro does not change the port list.
// TESTING (CLK_DIV=4, FIFO_DEPTH=4 unless noted)
//  1. Reset 3 cycles, no writes -> tx=1, busy=0, full=0, fifo_count=0, overflow=0 for 100 cycles.
//  2. Push 0xA5 once -> tx low 1 cycle after pop, for 4 cycles.
//     Then 1,0,1,0,0,1,0,1 each 4 cycles, then 1 for 4 cycles.
//     busy=1 for exactly 41 cycles from the push edge.
//  3. Push 0x01,0x02,0x03,0x04,0x05,0x06 on consecutive cycles ->
//     - full asserts after the 5th push (1st already popped); 6th dropped, overflow=1.
//     - Line carries 0x01..0x05 back-to-back with 1 idle cycle between frames.
//  4. Push 0x3C; assert reset during data bit 3 ->
//     - tx=1 next cycle, busy=0, fifo_count=0; no further edges on tx.
//  5. With FIFO full, push while the FSM pops in the same cycle ->
//     - Push dropped (full pre-edge), overflow=1.
//     - Repeat at fifo_count=3: count stays 3, byte accepted.
//  6. PARITY_EN defined, push 0x07 ->
//     - Frame: 0, 1,1,1,0,0,0,0,0, parity 1, stop 1; 44 cycles.

Source files
------------

// File: rtl/out_port_uart_tx.sv
// Output-port UART transmitter: byte FIFO draining into 8N1 frames on tx.
// Define OUT_PORT_UART_PARITY_EN to add an even-parity bit before stop.
module out_port_uart_tx #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned AW         = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          tx,
  output logic          busy,
  output logic          full,
  output logic [AW:0]   fifo_count,
  output logic          overflow
);

`ifdef OUT_PORT_UART_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
  } state_e;
`endif

  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0]   DIV_TC  = 16'(CLK_DIV - 1);

  state_e        state_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          ovf_q;
  logic          tx_q;
  logic [7:0]    shift_q;
  logic [2:0]    bit_q;
  logic [15:0]   div_q;
  logic          div_tc;
  logic          push;
  logic          pop;
`ifdef OUT_PORT_UART_PARITY_EN
  logic          par_q;
`endif

  assign full   = (count_q == DEPTH_C);
  assign push   = wr_en && !full;
  assign pop    = (state_q == IDLE) && (count_q != '0);
  assign div_tc = (div_q == DIV_TC);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) wptr_q <= wptr_q + PTR_ONE;
      if (pop)  rptr_q <= rptr_q + PTR_ONE;
      if (wr_en && full) ovf_q <= 1'b1;
    end
  end

  // Shift register holds the byte being sent; tx is loaded one bit ahead.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      shift_q <= '0;
      bit_q   <= '0;
      div_q   <= '0;
`ifdef OUT_PORT_UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (count_q != '0) begin
            shift_q <= mem_q[rptr_q];
`ifdef OUT_PORT_UART_PARITY_EN
            par_q   <= ^mem_q[rptr_q];
`endif
            div_q   <= '0;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (div_tc) begin
            div_q   <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            div_q <= div_q + 16'd1;
          end
        end
        DATA: begin
          if (div_tc) begin
            div_q   <= '0;
            bit_q   <= bit_q + 3'd1;
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_q == 3'd7) begin
`ifdef OUT_PORT_UART_PARITY_EN
              tx_q    <= par_q;
              state_q <= PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= STOP;
`endif
            end else begin
              tx_q <= shift_q[1];
            end
          end else begin
            div_q <= div_q + 16'd1;
          end
        end
`ifdef OUT_PORT_UART_PARITY_EN
        PARITY: begin
          if (div_tc) begin
            div_q   <= '0;
            tx_q    <= 1'b1;
            state_q <= STOP;
          end else begin
            div_q <= div_q + 16'd1;
          end
        end
`endif
        STOP: begin
          if (div_tc) begin
            div_q   <= '0;
            state_q <= IDLE;
          end else begin
            div_q <= div_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule
